minv_engine_param: RTL
======================

// Module: minv_engine_param
// PURPOSE
//  Parametrised modular-inverse engine: result = a^-1 mod p, odd p, binary extended Euclid.
//  Owns its FSM and a digit-serial add/sub datapath (DIGIT bits per cycle, NDIG=WIDTH/DIGIT cycles).
//  Generalises the fixed 256-bit/16-cycle inverse controller in:
//   - width and digit size;
//   - start/busy/done handshake;
//   - abort;
//   - operand-error detection.
//  Sits beside the modular multiplier in the PKC core; it is the inversion stage of the
//  projective-to-affine conversion.
// PARAMETERS
//  WIDTH  256  operand width in bits
//  DIGIT  16   adder slice width; WIDTH % DIGIT must be 0 (elaboration $error otherwise)
// PORTS
//  clk     in   1      clock, rising edge; the only clock
//  rst     in   1      reset: asynchronous assert, active-high
//  start   in   1      capture a and p and begin; ignored while busy=1
//  abort   in   1      return to IDLE next cycle; done is not pulsed
//  a       in   WIDTH  operand, sampled at start
//  p       in   WIDTH  modulus, sampled at start
//  busy    out  1      high from the cycle after start until done
//  done    out  1      one-cycle pulse when result/err are valid
//  err     out  1      a==0, a>=p, p even, p<3, or gcd(a,p)!=1; valid with done
//  result  out  WIDTH  inverse in [1,p-1]; 0 when err; held until next start
// BEHAVIOUR
//  Reset: state=IDLE; busy, done and err = 0; result = 0; all internal regs = 0.
//  Registers: u, v, x1, x2, t (WIDTH); carry/borrow flag; digit counter cnt (0..NDIG-1).
//  Initial values: u=a, v=p, x1=1, x2=0.
//  Digit-serial op: slice k = cnt is processed per cycle, starting at cnt=0 with
//   carry-in 0 for add and 1 (two's complement) for sub. Carry/borrow is kept from
//   cnt=NDIG-1.
//  States and transitions:
//   IDLE:   on start, latch operands, busy=1, go to CHECK.
//   CHECK (1 cycle):
//     - operand error -> DONE with err=1.
//     - else if u==1 or v==1 -> FIN.
//     - else if u[0]==0 -> HU.
//     - else if v[0]==0 -> HV.
//     - else -> SUV.
//   HU (1 cycle): u<=u>>1.
//     - x1 even: x1<=x1>>1, go to CHECK.
//     - x1 odd: go to AX1.
//   AX1 (NDIG cycles): x1<=(x1+p)>>1; the WIDTH+1-bit sum carry enters the MSB at the last
//     cycle; then go to CHECK.
//   HV / AX2: same as HU / AX1, applied to v and x2.
//   SUV (NDIG cycles): t=u-v. At the last digit:
//     - no borrow (u>=v): u<=t, go to SX1.
//     - borrow: go to SVU.
//   SVU (NDIG cycles): v<=v-u, go to SX2.
//   SX1 (NDIG cycles): x1<=x1-x2.
//     - borrow: go to PX1.
//     - no borrow: go to CHECK.
//   PX1 (NDIG cycles): x1<=x1+p, go to CHECK.
//   SX2 / PX2: same as SX1 / PX1, applied to x2-x1.
//  Zero check: in CHECK, u==0 or v==0 (gcd>1) -> DONE with err=1.
//  FIN (1 cycle): result <= (u==1) ? x1 : x2. When u==1 and v==1 both hold, x1 is used.
//  DONE (1 cycle): done=1, busy=0, then IDLE. The next start is accepted in IDLE, so the
//   minimum start-to-start spacing is done+1 cycles.
//  start during busy: no effect. abort with start in the same cycle: abort wins.
//  abort: result and err keep their previous values. Asserting rst mid-operation clears all
//   state immediately.
//  Termination: u+v strictly decreases, so the loop is bounded by 2*WIDTH iterations.
//  Worst case is below 2*WIDTH*(2+3*NDIG) cycles.
//  x1 and x2 stay in [0,p-1] throughout; no intermediate exceeds WIDTH+1 bits.
// TESTING
//  1. WIDTH=16,DIGIT=4: a=3, p=7 -> done pulse, result=5, err=0; busy low after done.
//  2. WIDTH=16,DIGIT=4: a=2, p=65521 -> result=32761, err=0.
//  3. Default params: a=2, p=2^255-19 -> result=2^254-9; latency < 2*256*(2+3*16).
//  4. Error cases, each must give done with err=1 and result=0:
//     a=0; a=p; p=65520 (even); a=6, p=9 (gcd 3).
//  5. abort 20 cycles after start -> IDLE next cycle, no done pulse.
//     Then start a=3, p=7 -> result=5.
//  6. rst pulsed mid-operation -> busy, done, err and result all 0 at once.
//     start pulsed while busy -> ignored; the original result is unchanged.
//     Random check: 10k odd p, random a<p, result*a mod p == 1.

Source files
------------

// File: rtl/minv_engine_param.sv
// Modular inverse a^-1 mod p by binary extended Euclid, with a digit-serial
// add/sub datapath processing DIGIT bits per cycle (NDIG cycles per wide op).
module minv_engine_param #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("minv_engine_param: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_HU, S_AX1, S_HV, S_AX2, S_SUV, S_SVU,
    S_SX1, S_PX1, S_SX2, S_PX2, S_FIN, S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [WIDTH-1:0] u_reg, u_next, v_reg, v_next;
  logic [WIDTH-1:0] x1_reg, x1_next, x2_reg, x2_next;
  logic [WIDTH-1:0] t_reg, t_next, p_reg, p_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             opnd_err_reg, opnd_err_next;
  logic             err_reg, err_next;

  // Operand selection for the shared slice adder
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub, serial;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    serial = 1'b1;
    case (state_reg)
      S_SUV:   begin op_a = u_reg;  op_b = v_reg;  op_sub = 1'b1; end
      S_SVU:   begin op_a = v_reg;  op_b = u_reg;  op_sub = 1'b1; end
      S_SX1:   begin op_a = x1_reg; op_b = x2_reg; op_sub = 1'b1; end
      S_SX2:   begin op_a = x2_reg; op_b = x1_reg; op_sub = 1'b1; end
      S_PX1,
      S_AX1:   begin op_a = x1_reg; op_b = p_reg; end
      S_PX2,
      S_AX2:   begin op_a = x2_reg; op_b = p_reg; end
      default: serial = 1'b0;
    endcase
  end

  logic [DIGIT-1:0] a_sl [NDIG];
  logic [DIGIT-1:0] b_sl [NDIG];
  logic [DIGIT:0]   sum_w;
  logic [WIDTH-1:0] t_full;
  logic             cin, cout, last_dig;

  assign last_dig = (cnt_reg == LAST);
  assign cin      = (cnt_reg == '0) ? op_sub : carry_reg;
  assign sum_w    = {1'b0, a_sl[cnt_reg]}
                  + {1'b0, (op_sub ? ~b_sl[cnt_reg] : b_sl[cnt_reg])}
                  + {{DIGIT{1'b0}}, cin};
  assign cout     = sum_w[DIGIT];

  // t_full is the partial result with the current slice merged in; at the
  // last digit it is the complete WIDTH-bit sum/difference.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
      assign a_sl[gi] = op_a[gi*DIGIT +: DIGIT];
      assign b_sl[gi] = op_b[gi*DIGIT +: DIGIT];
      assign t_full[gi*DIGIT +: DIGIT] =
        (cnt_reg == CW'(gi)) ? sum_w[DIGIT-1:0] : t_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    u_next        = u_reg;
    v_next        = v_reg;
    x1_next       = x1_reg;
    x2_next       = x2_reg;
    t_next        = t_reg;
    p_next        = p_reg;
    result_next   = result_reg;
    cnt_next      = cnt_reg;
    carry_next    = carry_reg;
    opnd_err_next = opnd_err_reg;
    err_next      = err_reg;

    if (serial) begin
      t_next     = t_full;
      carry_next = cout;
      cnt_next   = last_dig ? '0 : cnt_reg + CW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          u_next        = a;
          v_next        = p;
          x1_next       = WIDTH'(1);
          x2_next       = '0;
          t_next        = '0;
          p_next        = p;
          cnt_next      = '0;
          carry_next    = 1'b0;
          opnd_err_next = (a == '0) || (a >= p) || !p[0] || (p < WIDTH'(3));
          state_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        // u or v reaching zero means gcd(a,p) > 1
        if (opnd_err_reg || u_reg == '0 || v_reg == '0) begin
          err_next    = 1'b1;
          result_next = '0;
          state_next  = S_DONE;
        end else if (u_reg == WIDTH'(1) || v_reg == WIDTH'(1)) begin
          state_next = S_FIN;
        end else if (!u_reg[0]) begin
          state_next = S_HU;
        end else if (!v_reg[0]) begin
          state_next = S_HV;
        end else begin
          state_next = S_SUV;
        end
      end
      S_HU: begin
        u_next = u_reg >> 1;
        if (!x1_reg[0]) begin
          x1_next    = x1_reg >> 1;
          state_next = S_CHECK;
        end else begin
          state_next = S_AX1;
        end
      end
      S_HV: begin
        v_next = v_reg >> 1;
        if (!x2_reg[0]) begin
          x2_next    = x2_reg >> 1;
          state_next = S_CHECK;
        end else begin
          state_next = S_AX2;
        end
      end
      S_AX1: if (last_dig) begin
        x1_next    = {cout, t_full[WIDTH-1:1]};
        state_next = S_CHECK;
      end
      S_AX2: if (last_dig) begin
        x2_next    = {cout, t_full[WIDTH-1:1]};
        state_next = S_CHECK;
      end
      S_SUV: if (last_dig) begin
        if (cout) begin
          u_next     = t_full;
          state_next = S_SX1;
        end else begin
          state_next = S_SVU;
        end
      end
      S_SVU: if (last_dig) begin
        v_next     = t_full;
        state_next = S_SX2;
      end
      S_SX1: if (last_dig) begin
        x1_next    = t_full;
        state_next = cout ? S_CHECK : S_PX1;
      end
      S_SX2: if (last_dig) begin
        x2_next    = t_full;
        state_next = cout ? S_CHECK : S_PX2;
      end
      S_PX1: if (last_dig) begin
        x1_next    = t_full;
        state_next = S_CHECK;
      end
      S_PX2: if (last_dig) begin
        x2_next    = t_full;
        state_next = S_CHECK;
      end
      S_FIN: begin
        result_next = (u_reg == WIDTH'(1)) ? x1_reg : x2_reg;
        err_next    = 1'b0;
        state_next  = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Abort drops the operation but leaves the last reported result/err intact
    if (abort && state_reg != S_IDLE) begin
      state_next  = S_IDLE;
      cnt_next    = '0;
      carry_next  = 1'b0;
      result_next = result_reg;
      err_next    = err_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      u_reg        <= '0;
      v_reg        <= '0;
      x1_reg       <= '0;
      x2_reg       <= '0;
      t_reg        <= '0;
      p_reg        <= '0;
      result_reg   <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      opnd_err_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      u_reg        <= u_next;
      v_reg        <= v_next;
      x1_reg       <= x1_next;
      x2_reg       <= x2_next;
      t_reg        <= t_next;
      p_reg        <= p_next;
      result_reg   <= result_next;
      cnt_reg      <= cnt_next;
      carry_reg    <= carry_next;
      opnd_err_reg <= opnd_err_next;
      err_reg      <= err_next;
    end
  end

  assign busy   = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done   = (state_reg == S_DONE);
  assign err    = err_reg;
  assign result = result_reg;

endmodule
